ui_button_ctrl: RTL

Parametrised multi-button user-input controller for board-level control (noise level, display mode, test-pattern select).
- Per button: 2-FF synchroniser, debounce, short/long-press classification, auto-repeat while held.
- Per button: one wrap/saturate selection counter.
- Sits in the clk_dsp domain between raw board buttons and the DSP/display control registers; supersedes the single hard-wired debouncer/cycler in the system top.

---
 rtl/ui_button_ctrl_pkg.sv | 14 +
 rtl/ui_button_ctrl_btn_debounce.sv | 49 ++++
 rtl/ui_button_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ui_button_ctrl_pkg.sv
// Shared types and 27 MHz timing defaults for the board button controller.
package ui_button_ctrl_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESSED,
        BTN_HELD
    } btn_state_t;

    localparam int BTN_DEBOUNCE_27M = 540000;
    localparam int BTN_LONG_27M     = 27000000;
    localparam int BTN_REPEAT_27M   = 6750000;

endpackage

// File: rtl/ui_button_ctrl_btn_debounce.sv
// One button: polarity normalisation, 2-FF synchroniser and debounce filter.
module btn_debounce
    import ui_button_ctrl_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = BTN_DEBOUNCE_27M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             pressed_raw;
    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pressed_raw};
        end
    end

    // The new level is only accepted after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sync_q[1] == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync_q[1];
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign btn_level = stable_q;

endmodule

// File: rtl/ui_button_ctrl.sv
// Multi-button controller: debounce, short/long/repeat classification and a
// per-button selection counter.
module ui_button_ctrl
    import ui_button_ctrl_pkg::*;
#(
    parameter int N_BTN        = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = BTN_DEBOUNCE_27M,
    parameter int LONG_CYC     = BTN_LONG_27M,
    parameter int REPEAT_CYC   = BTN_REPEAT_27M,
    parameter int SEL_W        = 2,
    parameter int SEL_MAX      = 3,
    parameter int WRAP         = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       btn_raw,
    output logic [N_BTN-1:0]       btn_level,
    output logic [N_BTN-1:0]       press_short,
    output logic [N_BTN-1:0]       press_long,
    output logic [N_BTN-1:0]       press_repeat,
    output logic [N_BTN*SEL_W-1:0] sel,
    output logic [N_BTN-1:0]       sel_changed
);

    localparam int               HOLD_W    = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam int               REP_W     = (REPEAT_CYC > 0) ? $clog2(REPEAT_CYC + 1) : 1;
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
    localparam logic [SEL_W-1:0]  SEL_TOP   = SEL_W'(SEL_MAX);

    for (genvar k = 0; k < N_BTN; k++) begin : g_btn
        btn_state_t        state_q, state_nxt;
        logic [HOLD_W-1:0] hold_q, hold_nxt;
        logic [REP_W-1:0]  rep_q, rep_nxt;
        logic              short_q, long_q, repeat_q;
        logic              short_nxt, long_nxt, repeat_nxt;
        logic              level;
        logic [SEL_W-1:0]  sel_q;
        logic              changed_q;

        btn_debounce #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw   (btn_raw[k]),
            .btn_level (level)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= BTN_IDLE;
                hold_q   <= '0;
                rep_q    <= '0;
                short_q  <= 1'b0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
            end else begin
                state_q  <= state_nxt;
                hold_q   <= hold_nxt;
                rep_q    <= rep_nxt;
                short_q  <= short_nxt;
                long_q   <= long_nxt;
                repeat_q <= repeat_nxt;
            end
        end

        // Reaching the long threshold wins over a release seen in the same cycle.
        always_comb begin
            state_nxt = state_q;
            case (state_q)
                BTN_IDLE:    if (level) state_nxt = BTN_PRESSED;
                BTN_PRESSED: begin
                    if (hold_q == HOLD_LAST) state_nxt = BTN_HELD;
                    else if (!level)         state_nxt = BTN_IDLE;
                end
                BTN_HELD:    if (!level) state_nxt = BTN_IDLE;
                default:     state_nxt = BTN_IDLE;
            endcase
        end

        always_comb begin
            hold_nxt   = hold_q;
            rep_nxt    = rep_q;
            short_nxt  = 1'b0;
            long_nxt   = 1'b0;
            repeat_nxt = 1'b0;
            case (state_q)
                BTN_IDLE: begin
                    hold_nxt = '0;
                    rep_nxt  = '0;
                end
                BTN_PRESSED: begin
                    if (hold_q == HOLD_LAST) begin
                        long_nxt = 1'b1;
                        rep_nxt  = '0;
                    end else if (!level) begin
                        short_nxt = 1'b1;
                    end else begin
                        hold_nxt = hold_q + 1'b1;
                    end
                end
                BTN_HELD: begin
                    if (level && (REPEAT_CYC != 0)) begin
                        if (rep_q == REP_LAST) begin
                            repeat_nxt = 1'b1;
                            rep_nxt    = '0;
                        end else begin
                            rep_nxt = rep_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sel_q     <= '0;
                changed_q <= 1'b0;
            end else begin
                changed_q <= 1'b0;
                if (long_q) begin
                    sel_q     <= '0;
                    changed_q <= (sel_q != '0);
                end else if (short_q || repeat_q) begin
                    if (sel_q != SEL_TOP) begin
                        sel_q     <= sel_q + 1'b1;
                        changed_q <= 1'b1;
                    end else if (WRAP != 0) begin
                        sel_q     <= '0;
                        changed_q <= 1'b1;
                    end
                end
            end
        end

        assign btn_level[k]                = level;
        assign press_short[k]              = short_q;
        assign press_long[k]               = long_q;
        assign press_repeat[k]             = repeat_q;
        assign sel[k*SEL_W +: SEL_W]       = sel_q;
        assign sel_changed[k]              = changed_q;
    end

endmodule
